// File: rtl/selector_encoder.sv
// Turns four bouncy push-buttons into a held one-hot selection code for the
// seven-segment decoder. A code of 0000 means nothing is selected.
module selector_encoder #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int HOLD_CYCLES     = 0,
    parameter int CNT_W           = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn,
    input  logic       clear,
    output logic [3:0] code,
    output logic       valid,
    output logic       changed
);
    // state    | meaning
    // IDLE     | nothing selected, code 0000
    // SELECTED | one option latched, hold timer counting up
    typedef enum logic {IDLE = 1'b0, SELECTED = 1'b1} state_t;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [3:0]       sync1_q, sync2_q;
    logic [3:0]       db_q, db_d, db_dly_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       press, press_low;
    state_t           state_q, state_d;
    logic [3:0]       code_q, code_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic             valid_q, changed_q;

    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) db_d[i] = sync2_q[i];
                else cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    // Rising edges of the debounced level only; lowest index wins on a tie.
    assign press     = db_q & ~db_dly_q;
    assign press_low = press & (~press + 4'd1);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        hold_d  = hold_q;
        if (clear) begin
            state_d = IDLE;
            code_d  = 4'b0000;
            hold_d  = '0;
        end else if (press != 4'b0000) begin
            state_d = SELECTED;
            code_d  = press_low;
            hold_d  = '0;
        end else if (state_q == SELECTED) begin
            if ((HOLD_CYCLES != 0) && (hold_q == HOLD_LAST)) begin
                state_d = IDLE;
                code_d  = 4'b0000;
                hold_d  = '0;
            end else if (hold_q != CNT_MAX) begin
                hold_d = hold_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 4'b0000;
            sync2_q   <= 4'b0000;
            db_q      <= 4'b0000;
            db_dly_q  <= 4'b0000;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            state_q   <= IDLE;
            code_q    <= 4'b0000;
            hold_q    <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
            db_q      <= db_d;
            db_dly_q  <= db_q;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            state_q   <= state_d;
            code_q    <= code_d;
            hold_q    <= hold_d;
            valid_q   <= (code_d != 4'b0000);
            changed_q <= (code_d != code_q);
        end
    end

    assign code    = code_q;
    assign valid   = valid_q;
    assign changed = changed_q;

endmodule
